// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS-style execute-stage ALU.
// Holds the ALUctr operation encodings used by the ALU and by any decoder
// that drives it.
package mips_alu_pkg;

  localparam int unsigned CTRL_W = 3;

  // ALUctr encodings. Bit 2 selects subtraction in the shared adder and
  // bit 0 selects signed behaviour for the compare.
  localparam logic [CTRL_W-1:0] ALU_ADDU = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_OR   = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_RSVD = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SUBU = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_alu_addsub.sv
// Combinational add/subtract unit shared by arithmetic and compare.
// Ports:
//   a, b      - WIDTH-bit operands
//   sub       - 1 selects a - b (b inverted, carry-in 1), 0 selects a + b
//   sum       - WIDTH-bit sum, wraps modulo 2^WIDTH
//   carry_out - carry out of the most significant bit
//   ovf       - two's-complement overflow of this add/subtract
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;

  assign bx = b ^ {WIDTH{sub}};

  // One extra bit captures the carry; sub doubles as the carry-in so that
  // a + ~b + 1 gives two's-complement subtraction.
  assign {carry_out, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

  // Overflow: operands of equal sign (after inversion) yield a sum whose
  // sign differs from them.
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mips_alu.sv
// 32-bit MIPS-style integer ALU for the execute stage.
// Performs addu/add/or/subu/sub/sltu/slt selected by ALUctr; all outputs are
// registered, giving one cycle of latency and one operation per cycle.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   A, B        - operands
//   ALUctr      - operation select (see mips_alu_pkg)
//   Result      - selected operation result
//   Zero        - Result is all zeros
//   Overflow    - signed overflow, only for add and sub
//   Add_Result  - adder/subtractor output for every code
//   Less_Result - compare result, zero-extended 0/1
//   OR_Result   - A | B
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [CTRL_W-1:0] ALUctr,
  output logic [WIDTH-1:0]  Result,
  output logic              Zero,
  output logic              Overflow,
  output logic [WIDTH-1:0]  Add_Result,
  output logic [WIDTH-1:0]  Less_Result,
  output logic [WIDTH-1:0]  OR_Result
);

  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             add_ovf;

  logic             less_bit;
  logic [WIDTH-1:0] less_d;
  logic [WIDTH-1:0] or_d;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;

  assign sub = ALUctr[2];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a         (A),
    .b         (B),
    .sub       (sub),
    .sum       (sum),
    .carry_out (carry_out),
    .ovf       (add_ovf)
  );

  assign or_d = A | B;

  // The compare reuses the shared adder, which subtracts for the slt codes:
  // unsigned less is the missing carry, signed less is the sign corrected
  // for overflow.
  assign less_bit = ALUctr[0] ? (sum[WIDTH-1] ^ add_ovf) : ~carry_out;
  assign less_d   = {{(WIDTH-1){1'b0}}, less_bit};

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unique case (ALUctr)
      ALU_ADDU, ALU_SUBU: result_d = sum;
      ALU_ADD,  ALU_SUB: begin
        result_d = sum;
        ovf_d    = add_ovf;
      end
      ALU_OR:             result_d = or_d;
      ALU_SLTU, ALU_SLT:  result_d = less_d;
      ALU_RSVD:           result_d = '0;
      default:            result_d = '0;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      Result      <= '0;
      Zero        <= 1'b1;
      Overflow    <= 1'b0;
      Add_Result  <= '0;
      Less_Result <= '0;
      OR_Result   <= '0;
    end else begin
      Result      <= result_d;
      Zero        <= (result_d == '0);
      Overflow    <= ovf_d;
      Add_Result  <= sum;
      Less_Result <= less_d;
      OR_Result   <= or_d;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: a driver issues one operation per cycle
// and queues the reference response; a monitor pops and compares one entry
// after each rising edge.
module tb_mips_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ctr;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] add_result;
  logic [31:0] less_result;
  logic [31:0] or_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [31:0] add;
    logic [31:0] less;
    logic [31:0] orr;
    logic        zero;
    logic        ovf;
    logic        chk_less;
  } exp_t;

  exp_t exp_q[$];

  mips_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (a),
    .B           (b),
    .ALUctr      (ctr),
    .Result      (result),
    .Zero        (zero),
    .Overflow    (overflow),
    .Add_Result  (add_result),
    .Less_Result (less_result),
    .OR_Result   (or_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: true integer arithmetic, overflow when the exact
  // signed result does not survive truncation to 32 bits.
  function automatic exp_t model(input logic r, input logic [31:0] x,
                                 input logic [31:0] y, input logic [2:0] c,
                                 input string name);
    exp_t   e;
    longint sx;
    longint sy;
    longint exact;
    logic   lt;
    e.name = name;
    if (r) begin
      e.result = 32'h0; e.add = 32'h0; e.less = 32'h0; e.orr = 32'h0;
      e.zero = 1'b1; e.ovf = 1'b0; e.chk_less = 1'b1;
      return e;
    end
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (c[2]) begin
      e.add = x - y;
      exact = sx - sy;
    end else begin
      e.add = x + y;
      exact = sx + sy;
    end
    e.ovf = ((c == 3'b001) || (c == 3'b101)) &&
            (exact != longint'($signed(e.add)));
    lt = c[0] ? ($signed(x) < $signed(y)) : (x < y);
    e.less = {31'h0, lt};
    // The compare output is defined for the subtracting codes only.
    e.chk_less = c[2];
    e.orr = x | y;
    case (c)
      3'b010:         e.result = e.orr;
      3'b011:         e.result = 32'h0;
      3'b110, 3'b111: e.result = e.less;
      default:        e.result = e.add;
    endcase
    e.zero = (e.result == 32'h0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic apply(input logic r, input logic [31:0] x,
                       input logic [31:0] y, input logic [2:0] c,
                       input string name);
    @(negedge clk);
    rst = r;
    a   = x;
    b   = y;
    ctr = c;
    exp_q.push_back(model(r, x, y, c, name));
  endtask

  // Monitor: the DUT produces a result every cycle; one queued entry is
  // due right after each rising edge that follows its issue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".Result"},   result,     e.result);
        check({e.name, ".Zero"},     {31'h0, zero},     {31'h0, e.zero});
        check({e.name, ".Overflow"}, {31'h0, overflow}, {31'h0, e.ovf});
        check({e.name, ".Add"},      add_result, e.add);
        check({e.name, ".OR"},       or_result,  e.orr);
        if (e.chk_less) check({e.name, ".Less"}, less_result, e.less);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; a = '0; b = '0; ctr = '0;
    repeat (2) @(negedge clk);
    apply(1'b1, 32'h0, 32'h0, 3'b000, "reset");

    apply(1'b0, 32'hF2340000, 32'h80000000, 3'b000, "addu_wrap");
    apply(1'b0, 32'hF2340000, 32'h80000000, 3'b001, "add_negovf");
    apply(1'b0, 32'h7FFFFFFF, 32'h70000001, 3'b001, "add_posovf");
    apply(1'b0, 32'h7FFFFFFF, 32'hF0000001, 3'b001, "add_noovf");
    apply(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b001, "add_zero");
    apply(1'b0, 32'h00000000, 32'h00000000, 3'b010, "or_zero");
    apply(1'b0, 32'h7FFFFFFF, 32'hF0000001, 3'b010, "or_ones");
    apply(1'b0, 32'h7FFFFFFF, 32'hF0000001, 3'b100, "subu");
    apply(1'b0, 32'h7FFFFFFF, 32'hF0000001, 3'b101, "sub_ovf");
    apply(1'b0, 32'hF00FFFFF, 32'h7FFFFFF1, 3'b101, "sub_negovf");
    apply(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, "sub_zero");
    apply(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, "subu_zero");
    apply(1'b0, 32'hF0000000, 32'h0FFFFFFF, 3'b101, "sub_noovf");
    apply(1'b0, 32'h72340000, 32'hF0000000, 3'b110, "sltu_a");
    apply(1'b0, 32'h72340000, 32'hF0000000, 3'b111, "slt_a");
    apply(1'b0, 32'hF0001231, 32'h7AC34545, 3'b110, "sltu_b");
    apply(1'b0, 32'hF0001231, 32'h7AC34545, 3'b111, "slt_b");
    apply(1'b0, 32'h7000000F, 32'h7F000001, 3'b110, "sltu_c");
    apply(1'b0, 32'h7000000F, 32'h7F000001, 3'b111, "slt_c");
    apply(1'b0, 32'h7FFFFFFF, 32'h70000001, 3'b001, "pre_reset_add");
    apply(1'b1, 32'h7FFFFFFF, 32'h70000001, 3'b001, "midstream_reset");
    apply(1'b0, 32'h7FFFFFFF, 32'h70000001, 3'b001, "post_reset_add");
    apply(1'b0, 32'h12345678, 32'h9ABCDEF0, 3'b011, "reserved");

    for (int i = 0; i < 300; i++) begin
      logic r;
      r = ($urandom_range(0, 19) == 0);
      apply(r, pick(), pick(), 3'($urandom_range(0, 7)), "rand");
    end

    // Drain: the last entry must be consumed within a few cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit MIPS-style integer ALU for the single-cycle/pipelined datapath execute stage.
- Performs addu, add, or, subu, sub, sltu and slt, selected by a 3-bit control code.
- Also exports the intermediate adder, compare and OR results for debug and forwarding.
- All outputs are registered: one clock of latency from operand/control sample to result.

Parameters:
- WIDTH, 32, operand and result width. Test Plan values assume 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUctr  input  3  operation select (encoding below).
- Result  output  WIDTH  selected operation result.
- Zero  output  1  high when Result is all zeros.
- Overflow  output  1  signed overflow flag; only add/sub can set it.
- Add_Result  output  WIDTH  adder/subtractor output.
- Less_Result  output  WIDTH  compare result, zero-extended 0/1.
- OR_Result  output  WIDTH  A | B.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Encoding:
  - 000 addu; 001 add; 010 or; 011 reserved.
  - 100 subu; 101 sub; 110 sltu; 111 slt.
- Adder:
  - Single WIDTH-bit adder computes A + (B ^ {WIDTH{sub}}) + sub, where sub = ALUctr[2].
  - Add_Result is this sum for every code, including or and reserved.
  - Sum wraps modulo 2^WIDTH.
- Overflow:
  - Computed as (A[msb] == Bx[msb]) && (sum[msb] != A[msb]), where Bx is B after conditional inversion.
  - Output only for codes 001 and 101; 0 for all other codes.
- Compare:
  - Unsigned less = NOT carry-out of A + ~B + 1.
  - Signed less = sum[msb] XOR signed-overflow of the subtraction.
  - Less_Result = {WIDTH-1 zeros, less}; signed when ALUctr[0]=1, unsigned when ALUctr[0]=0.
- Result:
  - Add_Result for codes 000/001/100/101.
  - OR_Result for 010.
  - Less_Result for 110/111.
  - All zeros for reserved 011.
- Zero = (Result == 0), computed from the value being registered, so it is coherent with Result in the same cycle.
- Timing: on each rising edge with rst=0, all six outputs register the combinational values of the current A/B/ALUctr. Latency is 1 cycle, throughput 1 op per cycle, no handshake.
- Reset:
  - When rst=1 at an edge: Result, Add_Result, Less_Result, OR_Result = 0; Overflow = 0; Zero = 1.
  - Reset mid-stream discards the in-flight op; the first valid result appears the cycle after rst deasserts.
- No exceptions or traps: Overflow is a flag only, and Result still holds the wrapped sum.

Decomposition:
- Shared package holds the ALUctr encoding constants: ALU_ADDU, ALU_ADD, ALU_OR, ALU_SUBU, ALU_SUB, ALU_SLTU, ALU_SLT.
- One natural sub-module: alu_addsub. It is combinational and produces sum, carry-out and signed overflow from A, B and sub. It serves both arithmetic and compare.

Test Plan:
- Reset, then ALUctr=000 with A=F2340000, B=80000000 -> next cycle Result=72340000, Overflow=0, Zero=0.
- ALUctr=001:
  - A=F2340000, B=80000000 -> Result=72340000, Overflow=1.
  - A=7FFFFFFF, B=70000001 -> Result=F0000000, Overflow=1.
  - A=7FFFFFFF, B=F0000001 -> Result=70000000, Overflow=0.
  - A=FFFFFFFF, B=00000001 -> Result=0, Zero=1, Overflow=0.
- ALUctr=010:
  - A=0, B=0 -> Result=0, Zero=1.
  - A=7FFFFFFF, B=F0000001 -> Result=FFFFFFFF, OR_Result=FFFFFFFF.
- ALUctr=100/101:
  - A=7FFFFFFF, B=F0000001 -> Result=8FFFFFFE; Overflow 0 for subu, 1 for sub.
  - sub with A=F00FFFFF, B=7FFFFFF1 -> Result=7010000E, Overflow=1.
  - A=B=FFFFFFFF -> Result=0, Zero=1.
  - A=F0000000, B=0FFFFFFF -> Result=E0000001, Overflow=0.
- ALUctr=110/111:
  - A=72340000, B=F0000000 -> sltu Result=1, slt Result=0.
  - A=F0001231, B=7AC34545 -> sltu 0, slt 1.
  - A=7000000F, B=7F000001 -> both 1.
- Assert rst mid-stream during an add that overflows -> next cycle all outputs 0, Zero=1, Overflow=0. ALUctr=011 -> Result=0, Zero=1.
